// File: rtl/axi4lite_master.sv
// AXI4-Lite master: turns single CMD requests into AW/W/B or AR/R transfers with one transfer in flight.
// Optional response timeout enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4lite_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      A_CLK,
  input  logic                      A_RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WRITE,
  input  logic [AXI_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0] CMD_WDATA,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [AXI_DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic                      AW_VALID,
  input  logic                      AW_READY,
  output logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
  output logic                      W_VALID,
  input  logic                      W_READY,
  output logic [AXI_DATA_WIDTH-1:0] W_DATA,
  input  logic                      B_VALID,
  output logic                      B_READY,
  input  logic [1:0]                B_RESP,
  output logic                      AR_VALID,
  input  logic                      AR_READY,
  output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  input  logic                      R_VALID,
  output logic                      R_READY,
  input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
  input  logic [1:0]                R_RESP
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  logic [2:0]                state, state_nxt;
  logic                      cmd_ready_q, cmd_ready_nxt;
  logic                      rsp_valid_q, rsp_valid_nxt;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic [1:0]                rsp_resp_q, rsp_resp_nxt;
  logic                      aw_valid_q, aw_valid_nxt;
  logic                      w_valid_q, w_valid_nxt;
  logic                      b_ready_q, b_ready_nxt;
  logic                      ar_valid_q, ar_valid_nxt;
  logic                      r_ready_q, r_ready_nxt;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_nxt;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_nxt;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_nxt;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             busy;
`endif

  // State and registered outputs
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      ar_addr_q   <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_resp_q  <= rsp_resp_nxt;
      aw_valid_q  <= aw_valid_nxt;
      w_valid_q   <= w_valid_nxt;
      b_ready_q   <= b_ready_nxt;
      ar_valid_q  <= ar_valid_nxt;
      r_ready_q   <= r_ready_nxt;
      aw_addr_q   <= aw_addr_nxt;
      w_data_q    <= w_data_nxt;
      ar_addr_q   <= ar_addr_nxt;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_nxt;
`endif
    end
  end

  // Next state and next output values; every next value depends only on registered state plus inputs
  always_comb begin
    state_nxt     = state;
    cmd_ready_nxt = cmd_ready_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_resp_nxt  = rsp_resp_q;
    aw_valid_nxt  = aw_valid_q;
    w_valid_nxt   = w_valid_q;
    b_ready_nxt   = b_ready_q;
    ar_valid_nxt  = ar_valid_q;
    r_ready_nxt   = r_ready_q;
    aw_addr_nxt   = aw_addr_q;
    w_data_nxt    = w_data_q;
    ar_addr_nxt   = ar_addr_q;

    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          cmd_ready_nxt = 1'b0;
          if (CMD_WRITE) begin
            state_nxt    = WR_REQ;
            aw_valid_nxt = 1'b1;
            w_valid_nxt  = 1'b1;
            aw_addr_nxt  = CMD_ADDR;
            w_data_nxt   = CMD_WDATA;
          end else begin
            state_nxt    = RD_REQ;
            ar_valid_nxt = 1'b1;
            ar_addr_nxt  = CMD_ADDR;
          end
        end
      end
      // AW and W complete independently; a low VALID here means that channel is already done
      WR_REQ: begin
        if (aw_valid_q && AW_READY) aw_valid_nxt = 1'b0;
        if (w_valid_q && W_READY)   w_valid_nxt  = 1'b0;
        if (!aw_valid_nxt && !w_valid_nxt) begin
          state_nxt   = WR_RESP;
          b_ready_nxt = 1'b1;
        end
      end
      WR_RESP: begin
        if (B_VALID) begin
          state_nxt     = DONE;
          b_ready_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_resp_nxt  = B_RESP;
          rsp_rdata_nxt = '0;
        end
      end
      RD_REQ: begin
        if (AR_READY) begin
          state_nxt    = RD_RESP;
          ar_valid_nxt = 1'b0;
          r_ready_nxt  = 1'b1;
        end
      end
      RD_RESP: begin
        if (R_VALID) begin
          state_nxt     = DONE;
          r_ready_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_resp_nxt  = R_RESP;
          rsp_rdata_nxt = R_DATA;
        end
      end
      DONE: begin
        if (RSP_READY) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        cmd_ready_nxt = 1'b1;
      end
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    busy        = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_REQ) || (state == RD_RESP);
    tmo_cnt_nxt = busy ? tmo_cnt + TMO_W'(1) : '0;
    // Only fires when no handshake moved the FSM on this cycle
    if (busy && (state_nxt == state) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_nxt     = DONE;
      aw_valid_nxt  = 1'b0;
      w_valid_nxt   = 1'b0;
      b_ready_nxt   = 1'b0;
      ar_valid_nxt  = 1'b0;
      r_ready_nxt   = 1'b0;
      rsp_valid_nxt = 1'b1;
      rsp_resp_nxt  = RESP_TIMEOUT;
      rsp_rdata_nxt = '0;
    end
`endif
  end

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;
  assign AW_VALID  = aw_valid_q;
  assign AW_ADDR   = aw_addr_q;
  assign W_VALID   = w_valid_q;
  assign W_DATA    = w_data_q;
  assign B_READY   = b_ready_q;
  assign AR_VALID  = ar_valid_q;
  assign AR_ADDR   = ar_addr_q;
  assign R_READY   = r_ready_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Self-checking bench for axi4lite_master: per-scenario tasks, slave driven inline, completions scored from a queue.
module tb_axi4lite_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          A_CLK, A_RST;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_WDATA;
  logic          RSP_VALID, RSP_READY;
  logic [DW-1:0] RSP_RDATA;
  logic [1:0]    RSP_RESP;
  logic          AW_VALID, AW_READY;
  logic [AW-1:0] AW_ADDR;
  logic          W_VALID, W_READY;
  logic [DW-1:0] W_DATA;
  logic          B_VALID, B_READY;
  logic [1:0]    B_RESP;
  logic          AR_VALID, AR_READY;
  logic [AW-1:0] AR_ADDR;
  logic          R_VALID, R_READY;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;
  rsp_t exp_q[$];

  axi4lite_master #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  initial A_CLK = 1'b0;
  always #5 A_CLK = ~A_CLK;

  // Presents a command at a falling edge and returns one cycle after acceptance
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n = 0;
    @(negedge A_CLK);
    while (!CMD_READY && n < 50) begin
      @(negedge A_CLK);
      n++;
    end
    n_cmp++;
    if (!CMD_READY) begin
      n_err++;
      $display("FAIL issue_wait: CMD_READY=%0b after %0d cycles, required 1", CMD_READY, n);
    end
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = data;
    @(negedge A_CLK);
    CMD_VALID = 1'b0;
  endtask

  // Waits for a completion, scores it against the queue head, then consumes it
  task automatic collect_rsp(input string tag);
    int   n = 0;
    rsp_t e;
    while (!RSP_VALID && n < 50) begin
      @(negedge A_CLK);
      n++;
    end
    n_cmp++;
    if (!RSP_VALID) begin
      n_err++;
      $display("FAIL %s_rsp_wait: RSP_VALID=0 after %0d cycles, required 1", tag, n);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_scoreboard: got completion with empty expectation queue", tag);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({RSP_RDATA, RSP_RESP} !== {e.rdata, e.resp}) begin
      n_err++;
      $display("FAIL %s_rsp: rdata=%h resp=%b, required rdata=%h resp=%b", tag, RSP_RDATA, RSP_RESP, e.rdata, e.resp);
    end
    RSP_READY = 1'b1;
    @(negedge A_CLK);
    RSP_READY = 1'b0;
    n_cmp++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin
      n_err++;
      $display("FAIL %s_return_idle: RSP_VALID=%b CMD_READY=%b, required 0 1", tag, RSP_VALID, CMD_READY);
    end
  endtask

  task automatic test_reset();
    A_RST = 1'b1;
    #12;
    n_cmp++;
    if ({AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, RSP_VALID} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_valids: AW/W/AR/B/R/RSP=%b, required 000000",
               {AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, RSP_VALID});
    end
    @(negedge A_CLK);
    A_RST = 1'b0;
    @(negedge A_CLK);
    n_cmp++;
    if (CMD_READY !== 1'b1) begin
      n_err++;
      $display("FAIL reset_cmd_ready: got %b, required 1", CMD_READY);
    end
    n_cmp++;
    if ({RSP_RDATA, RSP_RESP, AW_ADDR, AR_ADDR, W_DATA} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h resp=%b aw=%h ar=%h w=%h, required all 0",
               RSP_RDATA, RSP_RESP, AW_ADDR, AR_ADDR, W_DATA);
    end
  endtask

  task automatic test_write();
    exp_q.push_back('{rdata: '0, resp: 2'b00});
    issue(1'b1, 32'h4, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({AW_VALID, W_VALID, AW_ADDR, W_DATA, CMD_READY} !== {2'b11, 32'h4, 32'hDEADBEEF, 1'b0}) begin
        n_err++;
        $display("FAIL write_req_hold[%0d]: awv=%b wv=%b aw=%h w=%h cmdrdy=%b, required 1 1 4 deadbeef 0",
                 i, AW_VALID, W_VALID, AW_ADDR, W_DATA, CMD_READY);
      end
      if (i == 0) @(negedge A_CLK);
    end
    AW_READY = 1'b1;
    W_READY  = 1'b1;
    @(negedge A_CLK);
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    n_cmp++;
    if ({AW_VALID, W_VALID, B_READY} !== 3'b001) begin
      n_err++;
      $display("FAIL write_after_hs: awv=%b wv=%b bready=%b, required 0 0 1", AW_VALID, W_VALID, B_READY);
    end
    B_VALID = 1'b1;
    B_RESP  = 2'b00;
    @(negedge A_CLK);
    B_VALID = 1'b0;
    collect_rsp("write");
  endtask

  task automatic test_read();
    exp_q.push_back('{rdata: 32'hDEADBEEF, resp: 2'b00});
    issue(1'b0, 32'h4, '0);
    n_cmp++;
    if ({AR_VALID, AR_ADDR, AW_VALID} !== {1'b1, 32'h4, 1'b0}) begin
      n_err++;
      $display("FAIL read_req: arv=%b ar=%h awv=%b, required 1 4 0", AR_VALID, AR_ADDR, AW_VALID);
    end
    @(negedge A_CLK);
    AR_READY = 1'b1;
    @(negedge A_CLK);
    AR_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({AR_VALID, R_READY, RSP_VALID} !== 3'b010) begin
        n_err++;
        $display("FAIL read_r_wait[%0d]: arv=%b rready=%b rspv=%b, required 0 1 0", i, AR_VALID, R_READY, RSP_VALID);
      end
      @(negedge A_CLK);
    end
    R_VALID = 1'b1;
    R_DATA  = 32'hDEADBEEF;
    R_RESP  = 2'b00;
    @(negedge A_CLK);
    R_VALID = 1'b0;
    R_DATA  = 32'h0BAD0BAD;
    collect_rsp("read");
  endtask

  task automatic test_w_before_aw();
    exp_q.push_back('{rdata: '0, resp: 2'b10});
    issue(1'b1, 32'h10, 32'h12345678);
    W_READY = 1'b1;
    @(negedge A_CLK);
    W_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({AW_VALID, W_VALID, B_READY, AW_ADDR} !== {3'b100, 32'h10}) begin
        n_err++;
        $display("FAIL split_aw_pending[%0d]: awv=%b wv=%b bready=%b aw=%h, required 1 0 0 10",
                 i, AW_VALID, W_VALID, B_READY, AW_ADDR);
      end
      if (i < 2) @(negedge A_CLK);
    end
    AW_READY = 1'b1;
    @(negedge A_CLK);
    AW_READY = 1'b0;
    n_cmp++;
    if ({AW_VALID, W_VALID, B_READY} !== 3'b001) begin
      n_err++;
      $display("FAIL split_b_wait: awv=%b wv=%b bready=%b, required 0 0 1", AW_VALID, W_VALID, B_READY);
    end
    @(negedge A_CLK);
    B_VALID = 1'b1;
    B_RESP  = 2'b10;
    @(negedge A_CLK);
    B_VALID = 1'b0;
    B_RESP  = 2'b00;
    collect_rsp("split");
  endtask

  task automatic test_rsp_stall();
    exp_q.push_back('{rdata: 32'hA5A50001, resp: 2'b01});
    issue(1'b0, 32'h20, '0);
    AR_READY = 1'b1;
    @(negedge A_CLK);
    AR_READY = 1'b0;
    R_VALID  = 1'b1;
    R_DATA   = 32'hA5A50001;
    R_RESP   = 2'b01;
    @(negedge A_CLK);
    R_VALID  = 1'b0;
    R_DATA   = '0;
    R_RESP   = 2'b00;
    // A command offered while busy must be ignored
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 32'h99;
    CMD_WDATA = 32'h77;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({RSP_VALID, RSP_RDATA, RSP_RESP, CMD_READY, AW_VALID} !== {1'b1, 32'hA5A50001, 2'b01, 2'b00}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: rspv=%b rdata=%h resp=%b cmdrdy=%b awv=%b, required 1 a5a50001 01 0 0",
                 i, RSP_VALID, RSP_RDATA, RSP_RESP, CMD_READY, AW_VALID);
      end
      if (i == 4) CMD_VALID = 1'b0;
      @(negedge A_CLK);
    end
    collect_rsp("stall");
    @(negedge A_CLK);
    n_cmp++;
    if ({AW_VALID, W_VALID, CMD_READY} !== 3'b001) begin
      n_err++;
      $display("FAIL stall_no_queue: awv=%b wv=%b cmdrdy=%b, required 0 0 1", AW_VALID, W_VALID, CMD_READY);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 32'h40, 32'hCAFEF00D);
    n_cmp++;
    if (AW_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: awv=%b, required 1", AW_VALID);
    end
    #2 A_RST = 1'b1;
    #1;
    n_cmp++;
    if ({AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, RSP_VALID} !== 6'b0) begin
      n_err++;
      $display("FAIL rstmid_async: AW/W/AR/B/R/RSP=%b, required 000000",
               {AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, RSP_VALID});
    end
    @(negedge A_CLK);
    A_RST = 1'b0;
    @(negedge A_CLK);
    n_cmp++;
    if ({CMD_READY, AW_VALID, W_VALID, AW_ADDR} !== {3'b100, 32'h0}) begin
      n_err++;
      $display("FAIL rstmid_idle: cmdrdy=%b awv=%b wv=%b aw=%h, required 1 0 0 0", CMD_READY, AW_VALID, W_VALID, AW_ADDR);
    end
  endtask

  // Read followed directly by a write with a zero-wait slave; write must report zero read data
  task automatic test_back_to_back();
    exp_q.push_back('{rdata: 32'h13579BDF, resp: 2'b00});
    issue(1'b0, 32'h8, '0);
    AR_READY = 1'b1;
    R_VALID  = 1'b1;
    R_DATA   = 32'h13579BDF;
    R_RESP   = 2'b00;
    @(negedge A_CLK);
    AR_READY = 1'b0;
    @(negedge A_CLK);
    R_VALID  = 1'b0;
    collect_rsp("b2b_rd");
    exp_q.push_back('{rdata: '0, resp: 2'b01});
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 32'hC;
    CMD_WDATA = 32'h2468ACE0;
    @(negedge A_CLK);
    CMD_VALID = 1'b0;
    n_cmp++;
    if ({AW_VALID, W_VALID, AW_ADDR, W_DATA} !== {2'b11, 32'hC, 32'h2468ACE0}) begin
      n_err++;
      $display("FAIL b2b_accept: awv=%b wv=%b aw=%h w=%h, required 1 1 c 2468ace0", AW_VALID, W_VALID, AW_ADDR, W_DATA);
    end
    AW_READY = 1'b1;
    W_READY  = 1'b1;
    B_VALID  = 1'b1;
    B_RESP   = 2'b01;
    @(negedge A_CLK);
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    @(negedge A_CLK);
    B_VALID  = 1'b0;
    B_RESP   = 2'b00;
    collect_rsp("b2b_wr");
  endtask

`ifdef AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    exp_q.push_back('{rdata: '0, resp: 2'b11});
    issue(1'b0, 32'h30, '0);
    while (AR_VALID && n < 100) begin
      n++;
      @(negedge A_CLK);
    end
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL timeout_len: AR_VALID high %0d cycles, required 16", n);
    end
    n_cmp++;
    if ({AR_VALID, R_READY, RSP_VALID} !== 3'b001) begin
      n_err++;
      $display("FAIL timeout_drop: arv=%b rready=%b rspv=%b, required 0 0 1", AR_VALID, R_READY, RSP_VALID);
    end
    collect_rsp("timeout");
  endtask
`endif

  initial begin
    A_RST = 1'b1;
    CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
    RSP_READY = 1'b0;
    AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b0; B_RESP = 2'b00;
    AR_READY = 1'b0;
    R_VALID = 1'b0; R_DATA = '0; R_RESP = 2'b00;

    test_reset();
    test_write();
    test_read();
    test_w_before_aw();
    test_rsp_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef AXI_MASTER_TIMEOUT_EN
    test_timeout();
`endif

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected completions never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
